// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: size codes, FSM states
// and byte-strobe masks. Set MAU_MISALIGN_CHECK_EN for misalign errors.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } mau_state_e;

  function automatic logic [7:0] size_mask(
    input logic [1:0] size
  );
    logic [7:0] m;
    unique case (size)
      SZ_B:    m = MASK_B;
      SZ_H:    m = MASK_H;
      SZ_W:    m = MASK_W;
      default: m = MASK_D;
    endcase
    return m;
  endfunction

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_bits(
    input logic [1:0] size
  );
    logic [2:0] a;
    unique case (size)
      SZ_B:    a = 3'b000;
      SZ_H:    a = 3'b001;
      SZ_W:    a = 3'b011;
      default: a = 3'b111;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering: store strobe/data shift, load extract/extend.
// Ports: addr_lo, size, is_unsigned, wdata, rdata -> wstrb, wdata_lane, rdata_ext.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_lane,
  output logic [63:0] rdata_ext
);

  logic [5:0]  sh;
  logic [63:0] rd_sh;

  assign sh         = {addr_lo, 3'b000};
  assign wstrb      = size_mask(size) << addr_lo;
  assign wdata_lane = wdata << sh;
  assign rd_sh      = rdata >> sh;

  always_comb begin
    rdata_ext = rd_sh;
    unique case (size)
      SZ_B: rdata_ext = is_unsigned
        ? {56'b0, rd_sh[7:0]}
        : {{56{rd_sh[7]}}, rd_sh[7:0]};
      SZ_H: rdata_ext = is_unsigned
        ? {48'b0, rd_sh[15:0]}
        : {{48{rd_sh[15]}}, rd_sh[15:0]};
      SZ_W: rdata_ext = is_unsigned
        ? {32'b0, rd_sh[31:0]}
        : {{32{rd_sh[31]}}, rd_sh[31:0]};
      default: rdata_ext = rd_sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one core request -> one 64-bit bus beat -> one response.
// Ports: clk, rst (async low), req_*, resp_*, bus_*. Macro: MAU_MISALIGN_CHECK_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic [63:0] bus_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  mau_state_e  state;
  logic [7:0]  cnt;
  logic        r_wen;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_uns;

  logic [63:0] acc_addr;
  logic        acc_err;
  logic [63:0] rdata_ext;

`ifdef MAU_MISALIGN_CHECK_EN
  assign acc_addr = req_addr;
  assign acc_err  = |(req_addr[2:0] & align_bits(req_size));
`else
  // Misaligned low bits are dropped so the access lands on its natural slot.
  assign acc_addr = {req_addr[63:3],
                     req_addr[2:0] & ~align_bits(req_size)};
  assign acc_err  = 1'b0;
`endif

  mau_lane_align u_align (
    .addr_lo     (r_addr[2:0]),
    .size        (r_size),
    .is_unsigned (r_uns),
    .wdata       (r_wdata),
    .rdata       (bus_rdata),
    .wstrb       (bus_wstrb),
    .wdata_lane  (bus_wdata),
    .rdata_ext   (rdata_ext)
  );

  assign req_ready = (state == ST_IDLE);
  assign bus_we    = r_wen;
  assign bus_addr  = {r_addr[63:3], 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      bus_req    <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_wen   <= req_wen;
            r_addr  <= acc_addr;
            r_wdata <= req_wdata;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            cnt     <= '0;
            if (acc_err) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state   <= ST_BUS;
              bus_req <= 1'b1;
            end
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            state      <= ST_RESP;
            bus_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= r_wen ? '0 : rdata_ext;
          end else if (cnt == TO_LAST) begin
            state      <= ST_RESP;
            bus_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4).
// Expectations follow MAU_MISALIGN_CHECK_EN when it is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        bus_req;
  logic        bus_ack;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic [63:0] bus_rdata;

  int vectors = 0;
  int errors  = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .bus_req      (bus_req),
    .bus_ack      (bus_ack),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wen, input logic [63:0] addr,
                       input logic [1:0] size, input logic uns,
                       input logic [63:0] wd);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_wen = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = '0;

    repeat (2) tick();
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_busreq", bus_req, 1'b0);
    chk1("rst_rvalid", resp_valid, 1'b0);
    chk1("rst_rerr", resp_err, 1'b0);
    chk64("rst_rdata", resp_rdata, 64'h0);
    chk64("rst_baddr", bus_addr, 64'h0);
    rst = 1'b1;
    tick();

    // Ack while idle must not produce anything.
    bus_ack = 1'b1;
    bus_rdata = '1;
    tick();
    bus_ack = 1'b0;
    chk1("idle_ack_rv", resp_valid, 1'b0);
    chk1("idle_ack_br", bus_req, 1'b0);

    // Signed word load at 0x1004, ack on third bus cycle.
    issue(1'b0, 64'h1004, 2'b10, 1'b0, 64'h0);
    tick();
    req_valid = 1'b0;
    chk1("lw_busreq", bus_req, 1'b1);
    chk1("lw_ready", req_ready, 1'b0);
    chk1("lw_we", bus_we, 1'b0);
    chk64("lw_addr", bus_addr, 64'h1000);
    chk64("lw_strb", {56'b0, bus_wstrb}, 64'hF0);
    tick();
    chk1("lw_hold1", bus_req, 1'b1);
    tick();
    chk1("lw_hold2", bus_req, 1'b1);
    chk64("lw_addr2", bus_addr, 64'h1000);
    bus_ack = 1'b1;
    bus_rdata = 64'h8000_0000_0000_0000;
    tick();
    bus_ack = 1'b0;
    bus_rdata = '0;
    chk1("lw_rv", resp_valid, 1'b1);
    chk1("lw_err", resp_err, 1'b0);
    chk64("lw_data", resp_rdata, 64'hFFFF_FFFF_8000_0000);
    chk1("lw_bus_drop", bus_req, 1'b0);
    tick();
    chk1("lw_rv_once", resp_valid, 1'b0);
    chk1("lw_ready2", req_ready, 1'b1);

    // Byte store to lane 7.
    issue(1'b1, 64'h7, 2'b00, 1'b0, 64'hAB);
    tick();
    req_valid = 1'b0;
    chk1("sb_we", bus_we, 1'b1);
    chk64("sb_strb", {56'b0, bus_wstrb}, 64'h80);
    chk64("sb_lane", {56'b0, bus_wdata[63:56]}, 64'hAB);
    bus_ack = 1'b1;
    bus_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    bus_ack = 1'b0;
    chk1("sb_rv", resp_valid, 1'b1);
    chk1("sb_err", resp_err, 1'b0);
    chk64("sb_data", resp_rdata, 64'h0);
    tick();

    // Misaligned halfword load at 0x3.
    issue(1'b0, 64'h3, 2'b01, 1'b0, 64'h0);
    tick();
    req_valid = 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
    chk1("mis_busreq", bus_req, 1'b0);
    chk1("mis_rv", resp_valid, 1'b1);
    chk1("mis_err", resp_err, 1'b1);
    chk64("mis_data", resp_rdata, 64'h0);
    tick();
    chk1("mis_rv_once", resp_valid, 1'b0);
`else
    chk1("mis_busreq", bus_req, 1'b1);
    chk64("mis_addr", bus_addr, 64'h0);
    chk64("mis_strb", {56'b0, bus_wstrb}, 64'h0C);
    bus_ack = 1'b1;
    bus_rdata = 64'h0000_0000_8001_0000;
    tick();
    bus_ack = 1'b0;
    chk1("mis_rv", resp_valid, 1'b1);
    chk1("mis_err", resp_err, 1'b0);
    chk64("mis_data", resp_rdata, 64'hFFFF_FFFF_FFFF_8001);
    tick();
`endif

    // Unsigned byte load from lane 5.
    issue(1'b0, 64'h25, 2'b00, 1'b1, 64'h0);
    tick();
    req_valid = 1'b0;
    chk64("lbu_addr", bus_addr, 64'h20);
    chk64("lbu_strb", {56'b0, bus_wstrb}, 64'h20);
    bus_ack = 1'b1;
    bus_rdata = 64'h0000_9C00_0000_0000;
    tick();
    bus_ack = 1'b0;
    chk64("lbu_data", resp_rdata, 64'h9C);
    tick();

    // Timeout: no ack for four bus cycles.
    issue(1'b0, 64'h40, 2'b11, 1'b0, 64'h0);
    bus_rdata = '1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("to_busreq", bus_req, 1'b1);
      chk1("to_norv", resp_valid, 1'b0);
      tick();
    end
    chk1("to_rv", resp_valid, 1'b1);
    chk1("to_err", resp_err, 1'b1);
    chk64("to_data", resp_rdata, 64'h0);
    chk1("to_busdrop", bus_req, 1'b0);
    tick();
    chk1("to_rv_once", resp_valid, 1'b0);
    chk1("to_ready", req_ready, 1'b1);

    // Reset in the middle of a bus transaction.
    issue(1'b0, 64'h80, 2'b11, 1'b0, 64'h0);
    tick();
    req_valid = 1'b0;
    chk1("rb_busreq", bus_req, 1'b1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk1("rb_async", bus_req, 1'b0);
    chk1("rb_rv", resp_valid, 1'b0);
    tick();
    rst = 1'b1;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("rb_norv", resp_valid, 1'b0);
      chk1("rb_nobus", bus_req, 1'b0);
      tick();
    end
    chk1("rb_ready", req_ready, 1'b1);

    // Back-to-back requests with req_valid held high.
    issue(1'b0, 64'h8, 2'b11, 1'b0, 64'h0);
    tick();
    req_addr = 64'h10;
    chk64("bb_addr1", bus_addr, 64'h8);
    bus_ack = 1'b1;
    bus_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    bus_ack = 1'b0;
    chk1("bb_rv1", resp_valid, 1'b1);
    chk64("bb_data1", resp_rdata, 64'h0123_4567_89AB_CDEF);
    chk1("bb_noready", req_ready, 1'b0);
    chk1("bb_nobus", bus_req, 1'b0);
    tick();
    chk1("bb_ready", req_ready, 1'b1);
    chk1("bb_idle_bus", bus_req, 1'b0);
    tick();
    req_valid = 1'b0;
    chk1("bb_busreq2", bus_req, 1'b1);
    chk64("bb_addr2", bus_addr, 64'h10);
    bus_ack = 1'b1;
    bus_rdata = 64'hFEDC_BA98_7654_3210;
    tick();
    bus_ack = 1'b0;
    chk1("bb_rv2", resp_valid, 1'b1);
    chk64("bb_data2", resp_rdata, 64'hFEDC_BA98_7654_3210);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning bus-wait cycles before abort (8-bit counter).
REQ-002 SHALL have port clk, input, 1, meaning sole clock; rising edge active.
REQ-003 SHALL have port rst, input, 1, meaning asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1, meaning core load/store request present.
REQ-005 SHALL have port req_ready, output, 1, meaning unit can accept a request.
REQ-006 SHALL have ports req_wen (input, 1, store=1), req_addr (input, 64, byte address), req_wdata (input, 64, store data, LSB-aligned), req_size (input, 2: 00 B, 01 H, 10 W, 11 D) and req_unsigned (input, 1, zero-extend loads).
REQ-007 SHALL have ports resp_valid (output, 1), resp_rdata (output, 64, extended load data), resp_err (output, 1, misalign/timeout).
REQ-008 SHALL have bus ports bus_req (output, 1), bus_ack (input, 1), bus_we (output, 1), bus_addr (output, 64, 8-byte aligned), bus_wdata (output, 64, lane-shifted), bus_wstrb (output, 8), bus_rdata (input, 64).

Function
REQ-009 SHALL implement FSM IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-010 SHALL accept a request when req_valid&&req_ready at a rising edge, registering all req_* fields.
REQ-011 IDLE->BUS on an accepted aligned request; IDLE->RESP with resp_err=1 on an accepted misaligned request (when checking is enabled), with no bus_req issued.
REQ-012 In BUS, SHALL hold bus_req=1 and all bus_* outputs stable until the cycle bus_ack=1.
REQ-013 On bus_ack in BUS, SHALL capture bus_rdata and move to RESP; bus_req drops the cycle after ack.
REQ-014 SHALL count BUS cycles; when the count reaches TIMEOUT without ack, SHALL move to RESP with resp_err=1 and resp_rdata=0.
REQ-015 In RESP, resp_valid=1 for exactly one cycle, then IDLE; no back-pressure on response.
REQ-016 Latency: accepted at edge N -> bus_req high in cycle N+1; ack at edge M -> resp_valid high in cycle M+1; minimum 2 cycles to resp.
REQ-017 bus_addr = {req_addr[63:3], 3'b000}; bus_wstrb = size mask (1/3/15/255) shifted left by req_addr[2:0].
REQ-018 bus_wdata = req_wdata shifted left by 8*req_addr[2:0]; bits outside strobe are don't-care.
REQ-019 resp_rdata = captured bus_rdata shifted right by 8*req_addr[2:0], truncated to size, sign-extended unless req_unsigned or size D.
REQ-020 resp_rdata SHALL be 0 for stores and for any error response.
REQ-021 bus_ack outside BUS SHALL be ignored; req_valid outside IDLE SHALL be ignored (not queued).
REQ-022 Timeout counter SHALL clear on every entry to BUS.

Reset
REQ-023 rst low SHALL asynchronously force state IDLE, bus_req=0, resp_valid=0, resp_err=0, resp_rdata=0, counter=0, all registered fields 0.
REQ-024 Reset mid-BUS SHALL abandon the transaction with no response; a later bus_ack SHALL be ignored.

Configuration
REQ-025 Macro MAU_MISALIGN_CHECK_EN defined: address not a multiple of size -> error response per REQ-011.
REQ-026 Macro undefined: low address bits below size granularity are forced to zero and the access proceeds; resp_err only from timeout.

Structure
REQ-027 Package mau_pkg SHALL hold the size encodings, FSM state enum and size-to-mask constants.
REQ-028 Sub-module mau_lane_align SHALL be purely combinational: strobe/wdata shifting and load extract/extend.

Verification
REQ-029 Load W, addr 0x...1004, signed, bus_rdata 0x80000000_00000000, ack after 3 cycles -> bus_addr 0x...1000, wstrb 0xF0, resp_rdata 0xFFFFFFFF_80000000, resp_valid one cycle.
REQ-030 Store B, addr 0x...0007, wdata 0xAB -> bus_we=1, wstrb 0x80, bus_wdata[63:56]=0xAB, resp_rdata=0.
REQ-031 Load H, addr 0x...0003, macro defined -> no bus_req, resp_valid in next cycle with resp_err=1; macro undefined -> bus access at byte 2, wstrb 0x0C.
REQ-032 TIMEOUT=4, bus_ack never asserted -> resp_err=1 after 4 BUS cycles, bus_req then low.
REQ-033 rst low during BUS, then ack pulse -> bus_req low immediately, no resp_valid ever, req_ready=1 after release.
REQ-034 Back-to-back req_valid held high -> second request accepted only in the IDLE cycle following resp_valid.
